// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared constants and types for the writeback stage
package wb_pkg;

  localparam int DW_DEF = 16;
  localparam int AW_DEF = 4;

  localparam logic [1:0] SEL_ALU = 2'b00;
  localparam logic [1:0] SEL_MEM = 2'b01;
  localparam logic [1:0] SEL_PC2 = 2'b10;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    HALT_SEEN = 2'd1,
    HALTED    = 2'd2
  } haltState_t;

endpackage

// File: rtl/mem_wb_reg.sv
// rtl/mem_wb_reg.sv - MEM/WB field register with freeze/bubble/stall/load control
module mem_wb_reg
  import wb_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          freeze,
  input  logic          stall,
  input  logic          flush,
  input  logic          memValid,
  input  logic          memRegwrite,
  input  logic [AW-1:0] memDst,
  input  logic [1:0]    memSel,
  input  logic [DW-1:0] memAlu,
  input  logic [DW-1:0] memRdata,
  input  logic [DW-1:0] memPc2,
  input  logic          memHalt,
  output logic          wbValid,
  output logic          wbRegwrite,
  output logic [AW-1:0] wbDst,
  output logic [1:0]    wbSel,
  output logic [DW-1:0] wbAlu,
  output logic [DW-1:0] wbRdata,
  output logic [DW-1:0] wbPc2,
  output logic          wbHalt
);

  // Freeze outranks flush so a retired HLT keeps the tail still; flush outranks stall.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wbValid    <= 1'b0;
      wbRegwrite <= 1'b0;
      wbDst      <= '0;
      wbSel      <= SEL_ALU;
      wbAlu      <= '0;
      wbRdata    <= '0;
      wbPc2      <= '0;
      wbHalt     <= 1'b0;
    end else if (!freeze) begin
      if (flush) begin
        wbValid    <= 1'b0;
        wbRegwrite <= 1'b0;
        wbDst      <= '0;
        wbSel      <= SEL_ALU;
        wbAlu      <= '0;
        wbRdata    <= '0;
        wbPc2      <= '0;
        wbHalt     <= 1'b0;
      end else if (!stall) begin
        wbValid    <= memValid;
        wbRegwrite <= memRegwrite;
        wbDst      <= memDst;
        wbSel      <= memSel;
        wbAlu      <= memAlu;
        wbRdata    <= memRdata;
        wbPc2      <= memPc2;
        wbHalt     <= memHalt;
      end
    end
  end

endmodule

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - writeback stage: result select, RF write port, HLT tracking
// Optional write-before-read bypass to decode when WB_BYPASS_EN is defined.
module wb_stage
  import wb_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic          flush,
  input  logic          mem_valid,
  input  logic          mem_regwrite,
  input  logic [AW-1:0] mem_dst,
  input  logic [1:0]    mem_sel,
  input  logic [DW-1:0] mem_alu,
  input  logic [DW-1:0] mem_rdata,
  input  logic [DW-1:0] mem_pc2,
  input  logic          mem_halt,
  output logic [AW-1:0] DstReg,
  output logic [DW-1:0] DstData,
  output logic          WriteReg,
  output logic          wb_valid,
  output logic          halted
`ifdef WB_BYPASS_EN
  ,
  input  logic [AW-1:0] rf_src1,
  input  logic [AW-1:0] rf_src2,
  input  logic [DW-1:0] rf_data1,
  input  logic [DW-1:0] rf_data2,
  output logic [DW-1:0] fwd_data1,
  output logic [DW-1:0] fwd_data2
`endif
);

  logic          wbValid;
  logic          wbRegwrite;
  logic [AW-1:0] wbDst;
  logic [1:0]    wbSel;
  logic [DW-1:0] wbAlu;
  logic [DW-1:0] wbRdata;
  logic [DW-1:0] wbPc2;
  logic          wbHalt;
  logic          running;

  haltState_t state, stateNext;

  assign running = (state == RUN);

  mem_wb_reg #(.DW(DW), .AW(AW)) uMemWbReg (
    .clk         (clk),
    .rst         (rst),
    .freeze      (!running),
    .stall       (stall),
    .flush       (flush),
    .memValid    (mem_valid),
    .memRegwrite (mem_regwrite),
    .memDst      (mem_dst),
    .memSel      (mem_sel),
    .memAlu      (mem_alu),
    .memRdata    (mem_rdata),
    .memPc2      (mem_pc2),
    .memHalt     (mem_halt),
    .wbValid     (wbValid),
    .wbRegwrite  (wbRegwrite),
    .wbDst       (wbDst),
    .wbSel       (wbSel),
    .wbAlu       (wbAlu),
    .wbRdata     (wbRdata),
    .wbPc2       (wbPc2),
    .wbHalt      (wbHalt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= RUN;
    else      state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      RUN:       if (wbValid && wbHalt) stateNext = HALT_SEEN;
      HALT_SEEN: stateNext = HALTED;
      HALTED:    stateNext = HALTED;
      default:   stateNext = RUN;
    endcase
  end

  // The reserved select code falls through to the ALU result.
  always_comb begin
    DstData = wbAlu;
    case (wbSel)
      SEL_MEM: DstData = wbRdata;
      SEL_PC2: DstData = wbPc2;
      default: DstData = wbAlu;
    endcase
  end

  assign DstReg   = wbDst;
  assign WriteReg = wbValid && wbRegwrite && (wbDst != '0) && !wbHalt && running;
  assign wb_valid = wbValid && running;
  assign halted   = (state == HALTED);

`ifdef WB_BYPASS_EN
  assign fwd_data1 = (WriteReg && (DstReg == rf_src1)) ? DstData : rf_data1;
  assign fwd_data2 = (WriteReg && (DstReg == rf_src2)) ? DstData : rf_data2;
`endif

endmodule
